// File: rtl/uart_packet_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_packet_pkg
// Brief   : Shared types for the UART packet assembler (parser states, FIFO
//           entry). ST_CHECKSUM exists only with UART_PACKET_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
package uart_packet_pkg;

    localparam logic [7:0] DEFAULT_MAGIC     = 8'h51;
    localparam int         HEADER_ADDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_WAIT_MAGIC = 3'd0,
        ST_LEN_HI     = 3'd1,
        ST_LEN_LO     = 3'd2,
        ST_ADDR       = 3'd3,
        ST_PAYLOAD    = 3'd4
`ifdef UART_PACKET_CHECKSUM_EN
        ,
        ST_CHECKSUM   = 3'd5
`endif
    } state_t;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] address;
        logic        last;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/uart_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_packet_fifo
// Brief   : Registered synchronous FIFO of payload beats; head reads as zero
//           while empty. Push while full is accepted only alongside a pop.
// Revision: 1.0
// ============================================================================
module uart_packet_fifo
    import uart_packet_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  fifo_entry_t              push_data,
    input  logic                     pop,
    output fifo_entry_t              pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   C_DEPTH = (AW + 1)'(DEPTH);

    fifo_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign empty    = (r_count == '0);
    assign full     = (r_count == C_DEPTH);
    assign w_pop    = pop & ~empty;
    assign w_push   = push & (~full | w_pop);
    assign count    = r_count;
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module  : uart_packet_assembler
// Brief   : Parses the UART byte stream (magic, BE length, BE address, payload)
//           into addressed write beats. Define UART_PACKET_CHECKSUM_EN for the
//           trailing XOR checksum byte.
// Revision: 1.0
// ============================================================================
module uart_packet_assembler
    import uart_packet_pkg::*;
#(
    parameter logic [7:0] MAGIC      = DEFAULT_MAGIC,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [31:0] out_address,
    output logic        out_last,
    output logic        busy,
    output logic        overflow,
    output logic        framing_error,
    output logic        checksum_error
);

    localparam logic [1:0] C_LAST_ADDR_IDX = 2'(HEADER_ADDR_BYTES - 1);

    state_t      r_state, w_state_nxt, w_eop_state;
    logic [15:0] r_remaining, w_remaining_nxt;
    logic [31:0] r_address, w_address_nxt;
    logic [1:0]  r_addr_idx, w_addr_idx_nxt;
    logic        r_overflow;
    logic        r_framing, w_framing_nxt;
    logic        w_push, w_pop, w_full, w_empty;
    fifo_entry_t w_push_entry, w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;

`ifdef UART_PACKET_CHECKSUM_EN
    logic [7:0] r_xor, w_xor_nxt;
    logic       r_cksum_err, w_cksum_err_nxt;
    assign w_eop_state    = ST_CHECKSUM;
    assign checksum_error = r_cksum_err;
`else
    assign w_eop_state    = ST_WAIT_MAGIC;
    assign checksum_error = 1'b0;
`endif

    always_comb begin
        w_state_nxt          = r_state;
        w_remaining_nxt      = r_remaining;
        w_address_nxt        = r_address;
        w_addr_idx_nxt       = r_addr_idx;
        w_framing_nxt        = 1'b0;
        w_push               = 1'b0;
        w_push_entry.data    = in_data;
        w_push_entry.address = r_address;
        w_push_entry.last    = (r_remaining == 16'd1);
`ifdef UART_PACKET_CHECKSUM_EN
        w_xor_nxt            = r_xor;
        w_cksum_err_nxt      = 1'b0;
`endif
        if (in_valid) begin
            if (in_error) begin
                // Abort mid-packet; queued beats stay in the FIFO.
                if (r_state != ST_WAIT_MAGIC) begin
                    w_state_nxt   = ST_WAIT_MAGIC;
                    w_framing_nxt = 1'b1;
                end
            end else begin
                unique case (r_state)
                    ST_WAIT_MAGIC: begin
                        if (in_data == MAGIC) begin
                            w_state_nxt    = ST_LEN_HI;
                            w_addr_idx_nxt = '0;
                        end
                    end
                    ST_LEN_HI: begin
                        w_remaining_nxt = {in_data, r_remaining[7:0]};
                        w_state_nxt     = ST_LEN_LO;
`ifdef UART_PACKET_CHECKSUM_EN
                        w_xor_nxt       = 8'h00;
`endif
                    end
                    ST_LEN_LO: begin
                        w_remaining_nxt = {r_remaining[15:8], in_data};
                        w_state_nxt     = ST_ADDR;
                    end
                    ST_ADDR: begin
                        w_address_nxt  = {r_address[23:0], in_data};
                        w_addr_idx_nxt = r_addr_idx + 1'b1;
                        if (r_addr_idx == C_LAST_ADDR_IDX) begin
                            w_state_nxt = (r_remaining == '0) ? w_eop_state : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        // Address/remaining advance even if the FIFO drops the byte.
                        w_push          = 1'b1;
                        w_address_nxt   = r_address + 32'd1;
                        w_remaining_nxt = r_remaining - 16'd1;
`ifdef UART_PACKET_CHECKSUM_EN
                        w_xor_nxt       = r_xor ^ in_data;
`endif
                        if (r_remaining == 16'd1) begin
                            w_state_nxt = w_eop_state;
                        end
                    end
`ifdef UART_PACKET_CHECKSUM_EN
                    ST_CHECKSUM: begin
                        w_cksum_err_nxt = (in_data != r_xor);
                        w_state_nxt     = ST_WAIT_MAGIC;
                    end
`endif
                    default: w_state_nxt = ST_WAIT_MAGIC;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= ST_WAIT_MAGIC;
            r_remaining <= '0;
            r_address   <= '0;
            r_addr_idx  <= '0;
            r_overflow  <= 1'b0;
            r_framing   <= 1'b0;
`ifdef UART_PACKET_CHECKSUM_EN
            r_xor       <= '0;
            r_cksum_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_address   <= w_address_nxt;
            r_addr_idx  <= w_addr_idx_nxt;
            r_framing   <= w_framing_nxt;
            if (w_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
`ifdef UART_PACKET_CHECKSUM_EN
            r_xor       <= w_xor_nxt;
            r_cksum_err <= w_cksum_err_nxt;
`endif
        end
    end

    uart_packet_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .clear     (clear),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign out_valid     = ~w_empty;
    assign w_pop         = out_valid & out_ready;
    assign out_data      = w_head.data;
    assign out_address   = w_head.address;
    assign out_last      = w_head.last;
    assign busy          = (r_state != ST_WAIT_MAGIC) | (w_count != '0);
    assign overflow      = r_overflow;
    assign framing_error = r_framing;

endmodule
`default_nettype wire

// File: doc/uart_packet_assembler.md
# uart_packet_assembler

Consumes the received byte stream of the UART receiver (one-cycle `data_out_valid` pulses with `data_out` and `parity_error`) and parses it into addressed write beats for the memory/DMA path. Each packet is a magic byte, a 16-bit big-endian length, a 32-bit big-endian start address, then the payload. Payload bytes are buffered in a small FIFO, because the receiver has no backpressure. They are emitted on a ready/valid port with an incrementing address and a last flag.

## Interface
- `MAGIC`, 8'h51 ('Q'): packet start byte.
- `FIFO_DEPTH`, 8: payload FIFO entries; power of two, ≥2.
- `clock`  in  1  sole clock.
- `clear`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  one-cycle byte strobe from the UART receiver.
- `in_data`  in  8  received byte; sampled only when `in_valid`.
- `in_error`  in  1  parity error flag for the byte; sampled only when `in_valid`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head when `out_valid & out_ready`.
- `out_data`  out  8  payload byte.
- `out_address`  out  32  byte address.
- `out_last`  out  1  final payload byte of the packet.
- `busy`  out  1  state ≠ WAIT_MAGIC, or FIFO non-empty.
- `overflow`  out  1  sticky; a payload byte was dropped because the FIFO was full.
- `framing_error`  out  1  one-cycle pulse when a packet is aborted by `in_error`.
- `checksum_error`  out  1  one-cycle pulse on checksum mismatch.

## Operation
- States: WAIT_MAGIC, LEN_HI, LEN_LO, ADDR, PAYLOAD, CHECKSUM. CHECKSUM exists only with the macro.
- Transitions occur only on accepted bytes (`in_valid`).
- WAIT_MAGIC: `in_data == MAGIC` → LEN_HI. Any other byte is ignored silently.
- LEN_HI, LEN_LO: load `remaining[15:0]`.
- ADDR: 2-bit counter collects 4 bytes, MSB first, into `address`.
  - On the 4th byte: `remaining == 0` → end-of-packet handling (below); otherwise → PAYLOAD.
- End-of-packet handling: WAIT_MAGIC without the macro, CHECKSUM with it.
- PAYLOAD: each byte pushes {data, address, last = (remaining == 1)}, then `address += 1` (mod 2^32) and `remaining -= 1`.
  - At `remaining == 1` → end-of-packet handling.
- FIFO full (count == FIFO_DEPTH with no pop in the same cycle): byte dropped and `overflow` set. Address and remaining still advance. If the dropped byte was last, no `out_last` is emitted.
- Push and pop in the same cycle while full: push accepted, count unchanged.
- `in_error` with `in_valid` in any state other than WAIT_MAGIC:
  - byte discarded, `framing_error` pulses, state → WAIT_MAGIC;
  - already-queued bytes remain in the FIFO.
- `in_error` in WAIT_MAGIC: byte ignored, no pulse.
- Zero-length packet: header only, nothing pushed.
- `busy` is combinational from the state and FIFO count.

## Timing
- Reset: `clear` at a clock edge forces state WAIT_MAGIC, FIFO empty, counters 0, `address` 0, `overflow` 0.
  - Applies mid-packet as well; queued data is discarded.
- After reset, all outputs are 0 (`out_data`/`out_address` 0 while empty).
- Latency: payload `in_valid` at cycle N → `out_valid` at N+1 when the FIFO was empty. The FIFO is registered, with no input-to-output bypass.
- Output stability: `out_data`/`out_address`/`out_last` stay stable while `out_valid & ~out_ready`.
- `framing_error` and `checksum_error` assert in the cycle after the offending `in_valid`, for exactly one cycle.
- Input rate: one byte per cycle is tolerated; the UART rate is far lower.

## Configuration
- `UART_PACKET_CHECKSUM_EN` defined:
  - running XOR of all payload bytes, seeded 8'h00 at LEN_HI;
  - after the last payload byte (or after ADDR when length = 0), state CHECKSUM consumes one byte;
  - mismatch → `checksum_error` pulse; either way → WAIT_MAGIC;
  - payload bytes are already emitted; the checksum is advisory.
- Undefined: no CHECKSUM state or XOR register; `checksum_error` tied 0.

## Structure
- Package `uart_packet_pkg`:
  - state enum;
  - default `MAGIC`;
  - `HEADER_ADDR_BYTES = 4`;
  - FIFO entry struct {data[7:0], address[31:0], last}.
- Sub-module `uart_packet_fifo`: synchronous FIFO, depth `FIFO_DEPTH`, push/pop/full/empty/count, clear-able. The parser FSM stays in the top module.

## Test plan
- Packet 51 00 03 00 00 10 00 AA BB CC with `out_ready = 1` → beats (AA,0x1000,0), (BB,0x1001,0), (CC,0x1002,1); each `out_valid` one cycle after its `in_valid`; `busy` 0 afterwards.
- Leading bytes 00 FF, then 51 00 00 12 34 56 78 → no beats; `busy` high during the header only, then 0.
- `out_ready = 0`, 12-byte payload with FIFO_DEPTH 8 → first 8 bytes queued, `overflow` = 1. Then `out_ready = 1` → 8 beats at 0x0..0x7; no `out_last`.
- `in_error` on the 2nd payload byte of 51 00 04 … → 1 beat emitted, `framing_error` pulses once. A subsequent valid packet parses correctly.
- Address wrap: start FFFFFFFF, length 2 → addresses 0xFFFFFFFF then 0x00000000.
- Macro on: payload 01 02, checksum 03 → no error. Checksum 00 → `checksum_error` pulse.
- Mid-packet `clear` → outputs 0, FIFO empty.
